lfsr_seg_ctrl: RTL
==================

LFSR_SEG_CTRL -- requirements
Module: lfsr_seg_ctrl

Interface
REQ-001 SHALL provide parameter DIV_MAX, default 15: in RUN, one LFSR step every DIV_MAX+1 cycles; legal range 0..65535.
REQ-002 SHALL provide parameter DB_CYCLES, default 4: debounce stable-high count, 1..255; used only when the debounce macro is defined.
REQ-003 SHALL have port clk  in  1  system clock, all state on posedge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port step_btn  in  1  manual single-step request, level.
REQ-006 SHALL have port run_tog  in  1  one-cycle pulse, toggles IDLE/RUN.
REQ-007 SHALL have port load  in  1  one-cycle pulse, load seed.
REQ-008 SHALL have port seed  in  8  value loaded on load.
REQ-009 SHALL have port q  out  8  current LFSR state.
REQ-010 SHALL have port seg1  out  8  7-seg pattern for q[7:4].
REQ-011 SHALL have port seg2  out  8  7-seg pattern for q[3:0].
REQ-012 SHALL have port running  out  1  high in RUN state.
REQ-013 SHALL have port step_pulse  out  1  high one cycle after each edge at which q advanced.
REQ-014 SHALL have port seed_err  out  1  one-cycle pulse on rejected zero seed.

Function
REQ-015 SHALL implement the LFSR step as q_next = {q[4]^q[3]^q[2]^q[0], q[7:1]}.
REQ-016 SHALL implement an FSM with two states: IDLE and RUN; running = (state==RUN).
REQ-017 SHALL, in IDLE, advance q exactly once per detected step_btn press (REQ-032/033).
REQ-018 SHALL ignore step_btn in RUN; no presses are queued.
REQ-019 SHALL, on run_tog in IDLE, enter RUN with the divider cleared to 0; on run_tog in RUN, enter IDLE.
REQ-020 SHALL, in RUN, increment the divider each cycle, step q on the cycle where divider==DIV_MAX, and wrap the divider to 0 on that cycle.
REQ-021 SHALL give load top priority in either state: seed!=0 -> q<=seed, state<=IDLE, divider<=0, no step that cycle.
REQ-022 SHALL, on load with seed==0, leave q, state and divider unchanged and assert seed_err for one cycle.
REQ-023 SHALL apply priority load > run_tog > step: run_tog with a press in IDLE enters RUN and discards the press.
REQ-024 SHALL ensure q never becomes 8'h00.
REQ-025 SHALL drive seg1/seg2 combinationally from q, with zero latency after the q update.
REQ-026 SHALL use segment encoding bit7..bit1 = a..g and bit0 = dp (always 0), active-high.
REQ-027 SHALL use hex decode 0..F = FC,60,DA,F2,66,B6,BE,E0,FE,F6,EE,3E,9C,7A,9E,8E.
REQ-028 SHALL register step_pulse so that it is high in the cycle following the posedge at which q advanced.

Reset
REQ-029 SHALL, on rst, set q=8'h01, state=IDLE, divider=0, running=0, step_pulse=0, seed_err=0, and clear the debounce/edge state, giving seg1=FC and seg2=60.
REQ-030 SHALL let rst override load, run_tog and step_btn in the same cycle.
REQ-031 SHALL, on rst mid-RUN or mid-debounce, abandon the in-progress operation with no pending step after release.

Configuration
REQ-032 SHALL, with LFSR_CTRL_DEBOUNCE_EN undefined, detect a press at a posedge where step_btn=1 and the registered previous sample=0; q advances at that edge.
REQ-033 SHALL, with LFSR_CTRL_DEBOUNCE_EN defined, detect a press when step_btn has been sampled high on DB_CYCLES consecutive posedges, step once, and re-arm only after step_btn is sampled low; shorter pulses step nothing.

Verification
REQ-034 SHALL cover: rst -> q=01, seg1=FC, seg2=60, running=0.
REQ-035 SHALL cover: one step_btn press in IDLE -> q=80, seg1=FE, seg2=FC, one step_pulse; holding high gives no further steps.
REQ-036 SHALL cover: DIV_MAX=3, run_tog -> step every 4 cycles; after 255 steps q=01 again, with no q=00 ever.
REQ-037 SHALL cover: load with seed=00 -> q unchanged, seed_err high for exactly 1 cycle; load seed=A5 in RUN -> q=A5, running=0, seg1=EE, seg2=B6.
REQ-038 SHALL cover: same-cycle load(seed=3C) + run_tog + press -> q=3C, IDLE, no step_pulse.
REQ-039 SHALL cover: debounce macro defined, DB_CYCLES=4, 3-cycle glitch -> no step; 4-cycle hold -> exactly one step.

Source files
------------

// File: rtl/lfsr_seg_ctrl.sv
// lfsr_seg_ctrl: 8-bit Fibonacci LFSR with manual single-step and free-run
// modes, seed loading with zero-seed rejection, and a dual 7-segment hex
// display of the current state.
//
// Build option: define LFSR_CTRL_DEBOUNCE_EN to replace the simple rising-edge
// detector on step_btn with a stable-high debouncer of DB_CYCLES samples.
// Without the macro, DB_CYCLES is accepted but has no effect.
module lfsr_seg_ctrl #(
    parameter int unsigned DIV_MAX   = 15,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step_btn,
    input  logic       run_tog,
    input  logic       load,
    input  logic [7:0] seed,
    output logic [7:0] q,
    output logic [7:0] seg1,
    output logic [7:0] seg2,
    output logic       running,
    output logic       step_pulse,
    output logic       seed_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(DIV_MAX);

    state_t      state_r;
    logic [15:0] div_r;
    logic [7:0]  q_r;
    logic        step_pulse_r;
    logic        seed_err_r;
    logic        press_s;

    // One LFSR step; the all-zero lock-up state is unreachable from a
    // non-zero state, but is steered back to 8'h01 should it ever appear.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = 8'h01;
        end else begin
            r = {v[4] ^ v[3] ^ v[2] ^ v[0], v[7:1]};
        end
        return r;
    endfunction

    // Hex nibble to segments, bit7..bit1 = a..g, bit0 = dp (kept off).
    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0:    s = 8'hFC;
            4'h1:    s = 8'h60;
            4'h2:    s = 8'hDA;
            4'h3:    s = 8'hF2;
            4'h4:    s = 8'h66;
            4'h5:    s = 8'hB6;
            4'h6:    s = 8'hBE;
            4'h7:    s = 8'hE0;
            4'h8:    s = 8'hFE;
            4'h9:    s = 8'hF6;
            4'hA:    s = 8'hEE;
            4'hB:    s = 8'h3E;
            4'hC:    s = 8'h9C;
            4'hD:    s = 8'h7A;
            4'hE:    s = 8'h9E;
            4'hF:    s = 8'h8E;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

`ifdef LFSR_CTRL_DEBOUNCE_EN
    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

    logic [7:0] db_cnt_r;    // consecutive high samples before this edge (saturating)
    logic       db_armed_r;  // cleared after a press until the button is seen low

    // Press fires on the DB_CYCLES-th consecutive high sample, once per hold.
    assign press_s = step_btn && db_armed_r && (db_cnt_r == DB_LAST);

    // Debounce counter and re-arm flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_r   <= 8'd0;
            db_armed_r <= 1'b1;
        end else if (!step_btn) begin
            db_cnt_r   <= 8'd0;
            db_armed_r <= 1'b1;
        end else begin
            if (press_s) begin
                db_armed_r <= 1'b0;
            end
            if (db_cnt_r != DB_LAST) begin
                db_cnt_r <= db_cnt_r + 8'd1;
            end
        end
    end
`else
    logic btn_prev_r;

    // Press is a rising edge of the sampled button level.
    assign press_s = step_btn && !btn_prev_r;

    // Previous-sample register for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev_r <= 1'b0;
        end else begin
            btn_prev_r <= step_btn;
        end
    end
`endif

    // Control FSM: load > run_tog > step; q, status and pulses are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            div_r        <= 16'd0;
            q_r          <= 8'h01;
            step_pulse_r <= 1'b0;
            seed_err_r   <= 1'b0;
        end else begin
            step_pulse_r <= 1'b0;
            seed_err_r   <= 1'b0;
            if (load) begin
                // A rejected zero seed consumes the cycle without side effects.
                if (seed != 8'h00) begin
                    q_r     <= seed;
                    state_r <= ST_IDLE;
                    div_r   <= 16'd0;
                end else begin
                    seed_err_r <= 1'b1;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (run_tog) begin
                            state_r <= ST_RUN;
                            div_r   <= 16'd0;
                        end else if (press_s) begin
                            q_r          <= lfsr_next(q_r);
                            step_pulse_r <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // Button presses are dropped here, never queued.
                        if (run_tog) begin
                            state_r <= ST_IDLE;
                            div_r   <= 16'd0;
                        end else if (div_r == DIV_LAST) begin
                            q_r          <= lfsr_next(q_r);
                            step_pulse_r <= 1'b1;
                            div_r        <= 16'd0;
                        end else begin
                            div_r <= div_r + 16'd1;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        div_r   <= 16'd0;
                    end
                endcase
            end
        end
    end

    assign q          = q_r;
    assign running    = (state_r == ST_RUN);
    assign step_pulse = step_pulse_r;
    assign seed_err   = seed_err_r;
    assign seg1       = hex_to_seg(q_r[7:4]);
    assign seg2       = hex_to_seg(q_r[3:0]);

endmodule
